// File: rtl/os_pkg.sv
// Shared definitions for the output-stationary datapath: the feeder FSM
// states and the default geometry shared with the input FIFO and PE array.
package os_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } feeder_state_t;

   localparam int OS_BW  = 4;
   localparam int OS_COL = 8;

endpackage

// File: rtl/os_feeder_skew_line.sv
// One column of the diagonal skew: `delay` shift stages followed by an
// output register, so an element entering here leaves delay+1 cycles later.
module skew_line #(
   parameter int bw    = 4,
   parameter int delay = 0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_valid,
   input  logic [bw-1:0] i_data,
   output logic          o_valid,
   output logic [bw-1:0] o_data
);

   logic          w_tailValid;
   logic [bw-1:0] w_tailData;
   logic          r_outValid;
   logic [bw-1:0] r_outData;

   generate
      if (delay == 0) begin : g_direct
         assign w_tailValid = i_valid;
         assign w_tailData  = i_data;
      end else begin : g_shift
         logic [delay-1:0] r_stageValid;
         logic [bw-1:0]    r_stageData [delay];

         // Move every element one stage per cycle; bubbles travel with the data.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_stageValid <= '0;
               for (int i = 0; i < delay; i++) begin
                  r_stageData[i] <= '0;
               end
            end else begin
               r_stageValid[0] <= i_valid;
               r_stageData[0]  <= i_valid ? i_data : '0;
               for (int i = 1; i < delay; i++) begin
                  r_stageValid[i] <= r_stageValid[i-1];
                  r_stageData[i]  <= r_stageData[i-1];
               end
            end
         end

         assign w_tailValid = r_stageValid[delay-1];
         assign w_tailData  = r_stageData[delay-1];
      end
   endgenerate

   // Output register; an invalid slice is driven as zero toward the array.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_outValid <= 1'b0;
         r_outData  <= '0;
      end else begin
         r_outValid <= w_tailValid;
         r_outData  <= w_tailValid ? w_tailData : '0;
      end
   end

   assign o_valid = r_outValid;
   assign o_data  = r_outData;

endmodule

// File: rtl/os_feeder.sv
// Output-stationary input feeder: pulls one tile of k_len vectors from the
// input FIFO and re-emits them diagonally skewed onto the array's west edge.
module os_feeder
   import os_pkg::*;
#(
   parameter int bw    = OS_BW,
   parameter int col   = OS_COL,
   parameter int len_w = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [len_w-1:0]  k_len,
   output logic              busy,
   output logic              done,
   output logic              fifo_rd,
   input  logic [bw*col-1:0] fifo_data,
   input  logic              fifo_valid,
   output logic [bw*col-1:0] arr_data,
   output logic [col-1:0]    arr_valid
);

   localparam int             DCW        = $clog2(col + 1);
   localparam logic [DCW-1:0] LAST_DRAIN = DCW'(col - 1);

   feeder_state_t    r_state;
   feeder_state_t    w_nextState;
   logic [len_w-1:0] r_rcvCnt;
   logic [len_w-1:0] r_kLen;
   logic [DCW-1:0]   r_drainCnt;
   logic [len_w:0]   w_rcvPlus;
   logic             w_capture;
   logic             w_lastDrain;

   assign w_capture   = fifo_valid && (r_state == FETCH);
   assign w_rcvPlus   = {1'b0, r_rcvCnt} + {{len_w{1'b0}}, fifo_valid};
   assign w_lastDrain = (r_drainCnt == LAST_DRAIN);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state plus status outputs; the read strobe counts the vector arriving this cycle so no read is ever issued past k_len.
   always_comb begin
      w_nextState = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      fifo_rd     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (k_len != '0) begin
                  w_nextState = FETCH;
               end else begin
                  w_nextState = DRAIN;
               end
            end
         end
         FETCH: begin
            busy    = 1'b1;
            fifo_rd = (w_rcvPlus < {1'b0, r_kLen});
            if (w_capture && (w_rcvPlus == {1'b0, r_kLen})) begin
               w_nextState = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (w_lastDrain) begin
               done        = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Tile bookkeeping: latch the length at launch, count vectors captured during FETCH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rcvCnt <= '0;
         r_kLen   <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_rcvCnt <= '0;
         r_kLen   <= k_len;
      end else if (w_capture) begin
         r_rcvCnt <= r_rcvCnt + 1'b1;
      end
   end

   // Drain counter spans the col cycles needed for the last vector to reach the far column.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_drainCnt <= '0;
      end else if (r_state == DRAIN) begin
         r_drainCnt <= r_drainCnt + 1'b1;
      end else begin
         r_drainCnt <= '0;
      end
   end

   generate
      for (genvar c = 0; c < col; c++) begin : g_col
         skew_line #(
            .bw    (bw),
            .delay (c)
         ) u_skew (
            .clk     (clk),
            .reset_n (reset_n),
            .i_valid (w_capture),
            .i_data  (fifo_data[bw*c +: bw]),
            .o_valid (arr_valid[c]),
            .o_data  (arr_data[bw*c +: bw])
         );
      end
   endgenerate

endmodule

// File: tb/tb_os_feeder.sv
// Bench for os_feeder: a behavioural FIFO feeds the DUT, and a timeline model
// (capture history indexed by cycle) predicts every output each cycle.
`timescale 1ns/1ps
module tb_os_feeder;

   localparam int bw    = 4;
   localparam int col   = 8;
   localparam int len_w = 8;
   localparam int W     = bw * col;

   logic             clk        = 1'b0;
   logic             reset_n    = 1'b1;
   logic             start      = 1'b0;
   logic [len_w-1:0] k_len      = '0;
   logic             fifo_valid = 1'b0;
   logic [W-1:0]     fifo_data  = '0;
   logic             busy;
   logic             done;
   logic             fifo_rd;
   logic [W-1:0]     arr_data;
   logic [col-1:0]   arr_valid;

   int checks = 0;
   int errors = 0;

   // Timeline model: tile window plus every captured vector keyed by its capture cycle.
   int           cyc       = 0;
   bit           tileOn    = 1'b0;
   int           tileStart = 0;
   int           tileK     = 0;
   int           tileGot   = 0;
   int           doneAt    = -1;
   bit           acceptedNow;
   logic [W-1:0] capHist [int];

   // Behavioural input FIFO and observation counters.
   logic [W-1:0] fq [$];
   int           stallPct    = 0;
   int           emptyUntil  = 0;
   bit           spurious    = 1'b0;
   int           validsGiven = 0;
   int           colCount [col];
   int           doneCycle   = -1;
   int           tileStartCyc = 0;

   typedef struct {
      int kLen;
      int stall;
      bit pattern;
      int expLat;
   } tile_vec_t;

   tile_vec_t vecs [7];

   os_feeder #(
      .bw    (bw),
      .col   (col),
      .len_w (len_w)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .k_len      (k_len),
      .busy       (busy),
      .done       (done),
      .fifo_rd    (fifo_rd),
      .fifo_data  (fifo_data),
      .fifo_valid (fifo_valid),
      .arr_data   (arr_data),
      .arr_valid  (arr_valid)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Compare one value and log a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
      end
   endtask

   // One clock cycle: check outputs against the model, advance the model, then let the FIFO answer.
   task automatic cycleStep();
      logic [W-1:0]   eData;
      logic [W-1:0]   tmp;
      logic [col-1:0] eValid;
      bit             active, eBusy, eFetch, eRd, eDone, rdNow, wasOn;
      int             idx;
      #1;
      eData       = '0;
      eValid      = '0;
      active      = 1'b0;
      eBusy       = 1'b0;
      eFetch      = 1'b0;
      eRd         = 1'b0;
      eDone       = 1'b0;
      acceptedNow = 1'b0;
      if (!reset_n) begin
         tileOn = 1'b0;
         doneAt = -1;
         capHist.delete();
      end else begin
         active = tileOn && (cyc > tileStart);
         eBusy  = active && ((doneAt < 0) || (cyc <= doneAt));
         eFetch = active && (tileGot < tileK);
         eRd    = eFetch && ((tileGot + int'(fifo_valid)) < tileK);
         eDone  = active && (cyc == doneAt);
         for (int c = 0; c < col; c++) begin
            idx = cyc - 1 - c;
            if (capHist.exists(idx)) begin
               tmp                = capHist[idx];
               eValid[c]          = 1'b1;
               eData[bw*c +: bw]  = tmp[bw*c +: bw];
            end
         end
      end
      checkOutput("busy", 64'(busy), 64'(eBusy));
      checkOutput("done", 64'(done), 64'(eDone));
      checkOutput("fifo_rd", 64'(fifo_rd), 64'(eRd));
      checkOutput("arr_valid", 64'(arr_valid), 64'(eValid));
      checkOutput("arr_data", 64'(arr_data), 64'(eData));
      if (reset_n) begin
         wasOn = tileOn;
         if (eFetch && fifo_valid) begin
            capHist[cyc] = fifo_data;
            tileGot++;
            if (tileGot == tileK) doneAt = cyc + col;
         end
         if (eDone) tileOn = 1'b0;
         if (!wasOn && start) begin
            tileOn      = 1'b1;
            tileStart   = cyc;
            tileK       = int'(k_len);
            tileGot     = 0;
            doneAt      = (k_len == '0) ? cyc + col : -1;
            acceptedNow = 1'b1;
         end
      end
      rdNow = fifo_rd;
      for (int c = 0; c < col; c++) begin
         if (arr_valid[c] === 1'b1) colCount[c]++;
      end
      if (done === 1'b1) doneCycle = cyc;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      start = 1'b0;
      k_len = len_w'($urandom);
      if (reset_n && rdNow && (fq.size() > 0) && (cyc >= emptyUntil) &&
          (int'($urandom_range(99)) >= stallPct)) begin
         fifo_valid = 1'b1;
         fifo_data  = fq.pop_front();
         validsGiven++;
      end else begin
         fifo_data  = $urandom;
         fifo_valid = reset_n && spurious && !rdNow && !acceptedNow && ($urandom_range(3) == 0);
      end
   endtask

   // Drive start/k_len for the current cycle and run it.
   task automatic applyStimulus(input bit st, input int k);
      start = st;
      k_len = len_w'(k);
      cycleStep();
   endtask

   // Preload the FIFO with two spare vectors beyond the tile and clear the counters.
   task automatic beginTile(input int k, input int stall, input bit pattern);
      logic [W-1:0] vec;
      fq.delete();
      for (int v = 0; v < k + 2; v++) begin
         for (int c = 0; c < col; c++) begin
            vec[bw*c +: bw] = pattern ? bw'(8 * v + c) : bw'($urandom);
         end
         fq.push_back(vec);
      end
      stallPct    = stall;
      validsGiven = 0;
      doneCycle   = -1;
      for (int c = 0; c < col; c++) colCount[c] = 0;
      tileStartCyc = cyc;
   endtask

   // Run until done (bounded), then check read count and per-column emission count.
   task automatic waitTileDone(input int k, output int lat);
      for (int i = 0; (i < 4 * k + 3 * col + 40) && (doneCycle < 0); i++) cycleStep();
      checkOutput("tileDoneSeen", 64'(doneCycle >= 0), 64'(1));
      lat = doneCycle - tileStartCyc;
      checkOutput("readCount", 64'(validsGiven), 64'(k));
      for (int c = 0; c < col; c++) begin
         checkOutput($sformatf("colEmitted%0d", c), 64'(colCount[c]), 64'(k));
      end
   endtask

   task automatic runTile(input int k, input int stall, input bit pattern, output int lat);
      beginTile(k, stall, pattern);
      applyStimulus(1'b1, k);
      waitTileDone(k, lat);
   endtask

   // Main sequence: reset, table of back-to-back tiles, corner cases, random tiles.
   initial begin
      int lat;
      vecs[0] = '{4,   0,  1'b1, 13};
      vecs[1] = '{1,   0,  1'b0, 10};
      vecs[2] = '{0,   0,  1'b0, 8};
      vecs[3] = '{7,   0,  1'b0, 16};
      vecs[4] = '{2,   0,  1'b0, 11};
      vecs[5] = '{20,  30, 1'b0, -1};
      vecs[6] = '{255, 25, 1'b0, -1};

      #2 reset_n = 1'b0;
      @(negedge clk);
      cycleStep();
      cycleStep();
      reset_n = 1'b1;
      cycleStep();
      cycleStep();

      $display("[TB] table-driven tiles (back-to-back)");
      for (int i = 0; i < 7; i++) begin
         runTile(vecs[i].kLen, vecs[i].stall, vecs[i].pattern, lat);
         if (vecs[i].expLat >= 0) checkOutput("tileLatency", 64'(lat), 64'(vecs[i].expLat));
      end
      stallPct = 0;

      $display("[TB] underflow: FIFO empty for 5 cycles after start");
      cycleStep();
      beginTile(3, 0, 1'b0);
      emptyUntil = cyc + 7;
      applyStimulus(1'b1, 3);
      waitTileDone(3, lat);
      checkOutput("underflowLatency", 64'(lat), 64'(17));
      emptyUntil = 0;

      $display("[TB] start during DRAIN is ignored");
      cycleStep();
      beginTile(2, 0, 1'b0);
      applyStimulus(1'b1, 2);
      repeat (4) cycleStep();
      applyStimulus(1'b1, 5);
      waitTileDone(2, lat);
      checkOutput("drainStartLatency", 64'(lat), 64'(11));
      repeat (6) cycleStep();

      $display("[TB] reset mid-FETCH");
      beginTile(10, 0, 1'b0);
      applyStimulus(1'b1, 10);
      repeat (4) cycleStep();
      reset_n = 1'b0;
      cycleStep();
      cycleStep();
      reset_n   = 1'b1;
      doneCycle = -1;
      repeat (20) cycleStep();
      checkOutput("noDoneAfterReset", 64'(doneCycle < 0), 64'(1));

      $display("[TB] random tiles with stalls and stray valids");
      spurious = 1'b1;
      repeat (6) begin
         repeat ($urandom_range(3)) cycleStep();
         runTile(int'($urandom_range(40)), int'($urandom_range(40)), 1'b0, lat);
      end
      spurious = 1'b0;
      repeat (4) cycleStep();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
